// File: rtl/decoder2to4_pulse_if.sv
// decoder2to4_pulse_if: valid/ready code handshake feeding the pulse decoder.
// The master offers a 2-bit code; the slave (decoder) signals when it can take one.
interface decoder2to4_pulse_if;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_code;

  modport master (output in_valid, output in_code, input in_ready);
  modport slave  (input in_valid, input in_code, output in_ready);
endinterface

// File: rtl/decoder2to4_pulse.sv
// decoder2to4_pulse: sequential 2-to-4 decoder. An accepted code drives the
// matching one-hot line for PULSE_LEN cycles, followed by one all-zero GAP
// cycle with done=1, so consumers always see distinct pulses.
// Optional feature macro: DECODER2TO4_QUEUE_EN adds a one-entry pending buffer
// so a new code can be taken during ACTIVE/GAP and pulses run back-to-back
// with exactly one GAP cycle between them.
module decoder2to4_pulse #(
  parameter int PULSE_LEN = 4,
  parameter int CNT_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  decoder2to4_pulse_if.slave    in_bus,
  output logic [3:0]            Y,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_t;

  // Counter starts at PULSE_LEN-1 so that ACTIVE lasts exactly PULSE_LEN cycles.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [1:0]       code;
  logic [1:0]       code_next;
  logic [3:0]       y_next;
  logic             busy_next;
  logic             done_next;
  logic             xfer;

  function automatic logic [3:0] onehot(input logic [1:0] c);
    onehot = 4'b0001 << c;
  endfunction

`ifdef DECODER2TO4_QUEUE_EN
  logic       pend_full;
  logic       pend_full_next;
  logic [1:0] pend_code;
  logic [1:0] pend_code_next;

  // Ready whenever the single pending slot is free; in IDLE it is always free.
  assign in_bus.in_ready = !pend_full;
`else
  // Ready depends on state only, never on in_valid.
  assign in_bus.in_ready = (state == IDLE);
`endif

  assign xfer = in_bus.in_valid && in_bus.in_ready;

  // Next-state, counter, latched code and next registered outputs.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    code_next  = code;
`ifdef DECODER2TO4_QUEUE_EN
    pend_full_next = pend_full;
    pend_code_next = pend_code;
`endif
    case (state)
      IDLE: begin
        if (xfer) begin
          state_next = ACTIVE;
          cnt_next   = CNT_LOAD;
          code_next  = in_bus.in_code;
        end
      end
      ACTIVE: begin
        if (cnt == '0) begin
          state_next = GAP;
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
`ifdef DECODER2TO4_QUEUE_EN
        if (xfer) begin
          pend_full_next = 1'b1;
          pend_code_next = in_bus.in_code;
        end
`endif
      end
      GAP: begin
`ifdef DECODER2TO4_QUEUE_EN
        if (pend_full) begin
          state_next     = ACTIVE;
          cnt_next       = CNT_LOAD;
          code_next      = pend_code;
          pend_full_next = 1'b0;
        end else if (xfer) begin
          // A code taken during GAP goes live on the edge that ends GAP,
          // exactly as if it had passed through the buffer.
          state_next = ACTIVE;
          cnt_next   = CNT_LOAD;
          code_next  = in_bus.in_code;
        end else begin
          state_next = IDLE;
        end
`else
        state_next = IDLE;
`endif
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    y_next    = (state_next == ACTIVE) ? onehot(code_next) : 4'b0000;
    busy_next = (state_next != IDLE);
    done_next = (state_next == GAP);
  end

  // Control state and registered outputs; reset clears them asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      Y     <= 4'b0000;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef DECODER2TO4_QUEUE_EN
      pend_full <= 1'b0;
`endif
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      Y     <= y_next;
      busy  <= busy_next;
      done  <= done_next;
`ifdef DECODER2TO4_QUEUE_EN
      pend_full <= pend_full_next;
`endif
    end
  end

  // Code payload registers; only meaningful while qualified by state/pend_full.
  always_ff @(posedge clk) begin
    code <= code_next;
`ifdef DECODER2TO4_QUEUE_EN
    pend_code <= pend_code_next;
`endif
  end

endmodule
